// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the sync_fifo block.
package sync_fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDepth     = 8;

  typedef logic [DefDataWidth-1:0] data_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy-derived full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] FIFO [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wt_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == FullCount);
  assign empty = (count == '0);

  // Requests are qualified by the flags as they stood before the edge.
  assign wr_en = we && !full;
  assign rd_en = re && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      FIFO[wt_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) begin
        wt_ptr <= wt_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= FIFO[rd_ptr];
      end
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue scoreboard models stored data and occupancy.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int Depth = DefDepth;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  we  = 1'b0;
  logic  re  = 1'b0;
  data_t din = '0;
  logic  full;
  logic  empty;
  data_t dout;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;
`endif

  int checks = 0;
  int passes = 0;

  // Scoreboard state
  data_t sb_q[$];
  int    m_count = 0;
  data_t m_dout  = '0;

  sync_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .din   (din),
    .full  (full),
    .empty (empty),
    .dout  (dout)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    sb_q.delete();
    m_count = 0;
    m_dout  = '0;
  endtask

  // Drive one clock cycle of requests and advance the model; returns #1 after the edge.
  task automatic step(input logic w, input logic r, input data_t d);
    logic wa, ra;
    we  = w;
    re  = r;
    din = d;
    wa  = w && (m_count != Depth);
    ra  = r && (m_count != 0);
    if (ra) m_dout = sb_q.pop_front();
    if (wa) sb_q.push_back(d);
    if (wa && !ra) m_count++;
    if (ra && !wa) m_count--;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (dut.count !== 4'd0) $display("FAIL reset_count got %0d exp 0", dut.count);
    else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passes++;
    checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h exp 00", dout); else passes++;
    checks++;
    if (dut.wt_ptr !== 3'd0 || dut.rd_ptr !== 3'd0)
      $display("FAIL reset_ptrs got wt=%0d rd=%0d exp 0/0", dut.wt_ptr, dut.rd_ptr);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, data_t'(i * 4));
    checks++; if (dut.count !== 4'd5) $display("FAIL wr_count got %0d exp 5", dut.count);
    else passes++;
    checks++;
    if (dut.wt_ptr !== 3'd5 || dut.rd_ptr !== 3'd0)
      $display("FAIL wr_ptrs got wt=%0d rd=%0d exp 5/0", dut.wt_ptr, dut.rd_ptr);
    else passes++;
    checks++; if (dut.FIFO[4] !== 8'h10) $display("FAIL wr_fifo4 got %h exp 10", dut.FIFO[4]);
    else passes++;
    checks++;
    if (empty !== 1'b0 || full !== 1'b0)
      $display("FAIL wr_flags got e=%b f=%b exp 0/0", empty, full);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (dout !== m_dout || dout !== data_t'(i * 4))
        $display("FAIL rd_dout[%0d] got %h exp %h", i, dout, m_dout);
      else passes++;
    end
    checks++;
    if (dut.count !== 4'd0 || dut.rd_ptr !== 3'd5 || empty !== 1'b1)
      $display("FAIL rd_end got cnt=%0d rd=%0d e=%b exp 0/5/1", dut.count, dut.rd_ptr, empty);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, data_t'(i));
      checks++;
      if (dout !== m_dout || int'(dut.count) != m_count)
        $display("FAIL b2b[%0d] got dout=%h cnt=%0d exp %h/%0d", i, dout, dut.count, m_dout,
                 m_count);
      else passes++;
    end
    checks++;
    if (dut.count !== 4'd1 || dut.wt_ptr !== 3'd2 || dut.rd_ptr !== 3'd1 || dout !== 8'h04)
      $display("FAIL b2b_end got cnt=%0d wt=%0d rd=%0d dout=%h exp 1/2/1/04", dut.count,
               dut.wt_ptr, dut.rd_ptr, dout);
    else passes++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, data_t'(i));
      if (i == 8) begin
        checks++; if (full !== 1'b1) $display("FAIL full_after8 got %b exp 1", full);
        else passes++;
      end
    end
    checks++;
    if (dut.count !== 4'd8 || dut.wt_ptr !== 3'd0)
      $display("FAIL full_ignore9 got cnt=%0d wt=%0d exp 8/0", dut.count, dut.wt_ptr);
    else passes++;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (dout !== m_dout || dout !== data_t'(i))
        $display("FAIL full_drain[%0d] got %h exp %h", i, dout, m_dout);
      else passes++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL full_drain_empty got %b exp 1", empty);
    else passes++;
  endtask

  task automatic test_ignore();
    logic [2:0] wt, rd;
    data_t      d0;
    wt = dut.wt_ptr;
    rd = dut.rd_ptr;
    d0 = dout;
    step(1'b0, 1'b1, '0);
    checks++;
    if (dut.rd_ptr !== rd || dut.wt_ptr !== wt || dut.count !== 4'd0 || dout !== d0)
      $display("FAIL rd_empty got rd=%0d cnt=%0d dout=%h exp %0d/0/%h", dut.rd_ptr, dut.count,
               dout, rd, d0);
    else passes++;
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, data_t'(8'hA0 + i));
    wt = dut.wt_ptr;
    rd = dut.rd_ptr;
    step(1'b1, 1'b0, 8'hEE);
    checks++;
    if (dut.wt_ptr !== wt || dut.rd_ptr !== rd || dut.count !== 4'd8 || dout !== d0)
      $display("FAIL wr_full got wt=%0d cnt=%0d dout=%h exp %0d/8/%h", dut.wt_ptr, dut.count,
               dout, wt, d0);
    else passes++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b1)
      $display("FAIL err_flags got ov=%b un=%b exp 1/1", overflow, underflow);
    else passes++;
`endif
    // Simultaneous request while full: only the read may be taken, din is dropped.
    step(1'b1, 1'b1, 8'h55);
    checks++;
    if (dut.count !== 4'd7 || full !== 1'b0 || dout !== m_dout)
      $display("FAIL rw_full got cnt=%0d f=%b dout=%h exp 7/0/%h", dut.count, full, dout, m_dout);
    else passes++;
    while (m_count > 0) begin
      step(1'b0, 1'b1, '0);
      checks++; if (dout !== m_dout) $display("FAIL rw_full_drain got %h exp %h", dout, m_dout);
      else passes++;
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1 || underflow !== 1'b1)
      $display("FAIL err_sticky got ov=%b un=%b exp 1/1", overflow, underflow);
    else passes++;
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, data_t'(8'h31 + i));
    step(1'b1, 1'b1, 8'h34);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut.count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 ||
        dut.wt_ptr !== 3'd0 || dut.rd_ptr !== 3'd0)
      $display("FAIL async_rst got cnt=%0d e=%b dout=%h wt=%0d rd=%0d exp 0/1/00/0/0",
               dut.count, empty, dout, dut.wt_ptr, dut.rd_ptr);
    else passes++;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL async_rst_err got ov=%b un=%b exp 0/0", overflow, underflow);
    else passes++;
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'hAA);
    checks++;
    if (dut.FIFO[0] !== 8'hAA || dut.wt_ptr !== 3'd1)
      $display("FAIL resume got fifo0=%h wt=%0d exp AA/1", dut.FIFO[0], dut.wt_ptr);
    else passes++;
    step(1'b0, 1'b1, '0);
    checks++; if (dout !== m_dout) $display("FAIL resume_rd got %h exp %h", dout, m_dout);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_full();
    test_ignore();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
